rf_write_ctrl: RTL and testbench
================================

// Module: rf_write_ctrl
// PURPOSE
//  Write-side controller for the 2R1W 32b x 8 register file. Merges a
//  single-cycle producer (port A, ALU) and a multi-cycle producer with
//  handshake (port B, load/mul) onto the single RF write port via a B-side
//  FIFO. Bypasses the in-flight registered write to read operands and flags
//  reads of registers with a pending buffered write. Sits between execute/
//  writeback and the register file.
// PARAMETERS
//  DW     32  data width
//  AW     3   register address width (2**AW entries)
//  DEPTH  4   port-B FIFO entries (power of 2, >=2)
// PORTS
//  clk      in   1   clock, all state on posedge
//  n_rst    in   1   asynchronous active-low reset
//  a_valid  in   1   port A write request, always accepted
//  a_addr   in   AW  port A destination register
//  a_data   in   DW  port A write data
//  b_valid  in   1   port B write request
//  b_ready  out  1   port B accept; transfer when b_valid&&b_ready
//  b_addr   in   AW  port B destination register
//  b_data   in   DW  port B write data
//  rf_we    out  1   RF write enable (registered)
//  rf_wa    out  AW  RF write address (registered)
//  rf_wd    out  DW  RF write data (registered)
//  ra1,ra2  in   AW  decode read addresses (also drive RF ra1/ra2)
//  rf_rd1/2 in   DW  RF read data
//  op1,op2  out  DW  bypassed operands
//  busy1/2  out  1   ra1/ra2 matches a valid FIFO entry (decode must stall)
// BEHAVIOUR
//  Reset (async, n_rst=0): rf_we=0, rf_wa=0, rf_wd=0, FIFO empty, all entry
//   valid bits 0, rd/wr pointers 0; b_ready=1, busy1/2=0 during reset.
//  b_ready = (count < DEPTH); combinational from state only. No push when
//   full, even if a pop occurs the same cycle.
//  Per cycle, select one write source for next rf_we/rf_wa/rf_wd:
//   1) a_valid: A wins -> rf_we<=1, rf_wa<=a_addr, rf_wd<=a_data; no pop.
//   2) else FIFO non-empty: pop head; if head valid -> rf_we<=1 with head
//      addr/data; if head squashed -> rf_we<=0 (slot consumed, no write).
//   3) else rf_we<=0; rf_wa/rf_wd hold.
//  Latency: A -> rf_we 1 cycle. B -> rf_we >=2 cycles (push, then pop);
//   no bypass from b_* directly to rf_*.
//  Squash (A is architecturally younger than any B result): when a_valid,
//   every valid FIFO entry with addr==a_addr is invalidated, including a B
//   beat pushed in the same cycle with b_addr==a_addr (stored invalid).
//   Squashed entries keep occupying FIFO slots until popped.
//  Push and pop in the same cycle: count unchanged; pointers wrap mod DEPTH.
//  Write order to same register from B preserved (FIFO order).
//  opN = (rf_we && rf_wa==raN) ? rf_wd : rf_rdN  (combinational bypass of
//   the write committing at the next edge).
//  busyN = OR over FIFO entries of (valid && addr==raN); state only, does
//   not include a same-cycle incoming B beat.
//  Address 0 is an ordinary register (no hardwired zero).
//  Starvation of B under continuous a_valid is permitted; producer upstream
//   bounds A issue rate.
// TESTING
//  T1 reset: n_rst=0 mid-burst with FIFO 3 full -> rf_we=0, b_ready=1,
//     busy=0 immediately; after release FIFO empty, no stale writes.
//  T2 A only: a_valid, a_addr=3, a_data=0xDEADBEEF -> next cycle rf_we=1,
//     rf_wa=3, rf_wd=0xDEADBEEF; ra1=3 same cycle -> op1=0xDEADBEEF.
//  T3 B order: push B (5,0x11),(5,0x22), a_valid=0 -> rf writes 0x11 then
//     0x22 to r5 on consecutive cycles; busy1 (ra1=5) high until 2nd pop.
//  T4 backpressure: hold a_valid=1 (addr 7), push 4 B beats to r1..r4 ->
//     b_ready=0 after 4th; drop a_valid -> 4 writes drain, b_ready=1 again.
//  T5 squash: FIFO holds (2,0xAA); a_valid addr 2 data 0xBB with b_valid
//     addr 2 data 0xCC -> only r2=0xBB written; two squashed pops give
//     rf_we=0; busy for ra=2 clears the cycle after squash.
//  T6 wrap: 2*DEPTH+1 B beats with interleaved A -> all non-squashed data
//     written in order, count never exceeds DEPTH.

Source files
------------

// File: rtl/rf_write_ctrl.sv
// Write-side controller for the 2R1W register file: merges an always-accepted
// single-cycle producer (A) with a FIFO-buffered handshake producer (B).
module rf_write_ctrl #(
  parameter int DW    = 32,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [DW-1:0] op1,
  output logic [DW-1:0] op2,
  output logic          busy1,
  output logic          busy2
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic push;
  logic pop;
  logic b_squash;

  assign b_ready  = (count != FULL_CNT);
  assign push     = b_valid && b_ready;
  // A owns the write port whenever it is valid, so the FIFO only drains on idle-A cycles.
  assign pop      = !a_valid && (count != '0);
  // A is younger than anything from B, so a same-cycle B beat to the same register is dead on arrival.
  assign b_squash = a_valid && (b_addr == a_addr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Squashed entries stay in place and still consume a pop slot later.
      for (int i = 0; i < DEPTH; i++) begin
        if (a_valid && ent_valid[i] && (ent_addr[i] == a_addr))
          ent_valid[i] <= 1'b0;
      end
      if (pop)  ent_valid[rd_ptr] <= 1'b0;
      if (push) ent_valid[wr_ptr] <= !b_squash;
    end
  end

  // NOTE: the payload array has no reset; its valid bits alone decide whether a slot means anything.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= b_addr;
      ent_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (a_valid) begin
      rf_we <= 1'b1;
      rf_wa <= a_addr;
      rf_wd <= a_data;
    end else if (pop) begin
      rf_we <= ent_valid[rd_ptr];
      if (ent_valid[rd_ptr]) begin
        rf_wa <= ent_addr[rd_ptr];
        rf_wd <= ent_data[rd_ptr];
      end
    end else begin
      rf_we <= 1'b0;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy1 = busy1 | (ent_valid[i] && (ent_addr[i] == ra1));
      busy2 = busy2 | (ent_valid[i] && (ent_addr[i] == ra2));
    end
  end

  assign op1 = (rf_we && (rf_wa == ra1)) ? rf_wd : rf_rd1;
  assign op2 = (rf_we && (rf_wa == ra2)) ? rf_wd : rf_rd2;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the write-side behaviour.
module tb_rf_write_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk;
  logic          n_rst;
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic          busy1;
  logic          busy2;

  rf_write_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .op1(op1), .op2(op2), .busy1(busy1), .busy2(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            valid;
  } ent_t;

  // Model: pending B writes in arrival order, plus the write committing next edge.
  ent_t          mq[$];
  bit            m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  int n_vec;
  int n_err;

  function automatic bit exp_busy(input logic [AW-1:0] ra);
    foreach (mq[i]) if (mq[i].valid && mq[i].addr == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] ra, input logic [DW-1:0] rd);
    return (m_we && m_wa == ra) ? m_wd : rd;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic model_update();
    ent_t h;
    bit   do_push;
    do_push = b_valid && (mq.size() < DEPTH);
    if (a_valid) begin
      foreach (mq[i]) if (mq[i].addr == a_addr) mq[i].valid = 1'b0;
      m_we = 1'b1;
      m_wa = a_addr;
      m_wd = a_data;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_we = h.valid;
      if (h.valid) begin
        m_wa = h.addr;
        m_wd = h.data;
      end
    end else begin
      m_we = 1'b0;
    end
    if (do_push) mq.push_back('{b_addr, b_data, !(a_valid && b_addr == a_addr)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!n_rst) model_clear();
    else        model_update();
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ra1 = 3'd1; ra2 = 3'd2; rf_rd1 = 32'h1111_0001; rf_rd2 = 32'h2222_0002;
    n_rst = 1'b0;
    model_clear();
    repeat (2) tick();
    n_vec++;
    if (rf_we !== 1'b0 || rf_wa !== 3'd0 || rf_wd !== 32'd0) begin
      n_err++; $display("FAIL reset_rf: got we=%b wa=%0d wd=%h, want 0/0/0", rf_we, rf_wa, rf_wd);
    end
    n_vec++;
    if (b_ready !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0 || op1 !== rf_rd1) begin
      n_err++; $display("FAIL reset_flags: got ready=%b busy=%b%b op1=%h, want 1 00 %h", b_ready, busy1, busy2, op1, rf_rd1);
    end
    n_rst = 1'b1;
    // Fill three FIFO slots while A keeps the write port busy.
    a_valid = 1'b1; a_addr = 3'd7; a_data = 32'h7777_7777;
    for (int k = 1; k <= 3; k++) begin
      b_valid = 1'b1; b_addr = 3'(k); b_data = 32'h100 + k;
      tick();
    end
    b_addr = 3'd4;
    #1;
    n_vec++;
    if (busy1 !== 1'b1 || rf_we !== 1'b1 || b_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_prefill: got busy1=%b we=%b ready=%b, want 1 1 1", busy1, rf_we, b_ready);
    end
    #2;
    n_rst = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (rf_we !== 1'b0 || b_ready !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_err++; $display("FAIL reset_async: got we=%b ready=%b busy=%b%b, want 0 1 00", rf_we, b_ready, busy1, busy2);
    end
    tick();
    idle_inputs();
    n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0 || b_ready !== 1'b1) begin
        n_err++; $display("FAIL reset_after c%0d: got we=%b busy=%b%b ready=%b, want 0 00 1", c, rf_we, busy1, busy2, b_ready);
      end
    end
  endtask

  task automatic test_a_only();
    idle_inputs();
    a_valid = 1'b1; a_addr = 3'd3; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    ra1 = 3'd3; ra2 = 3'd4; rf_rd1 = $urandom; rf_rd2 = $urandom;
    #1;
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 3'd3 || rf_wd !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL a_write: got we=%b wa=%0d wd=%h, want 1/3/deadbeef", rf_we, rf_wa, rf_wd);
    end
    n_vec++;
    if (op1 !== 32'hDEAD_BEEF || op2 !== rf_rd2) begin
      n_err++; $display("FAIL a_bypass: got op1=%h op2=%h, want deadbeef %h", op1, op2, rf_rd2);
    end
    tick();
    n_vec++;
    if (rf_we !== 1'b0 || op1 !== rf_rd1) begin
      n_err++; $display("FAIL a_idle: got we=%b op1=%h, want 0 %h", rf_we, op1, rf_rd1);
    end
  endtask

  task automatic test_b_order();
    idle_inputs();
    ra1 = 3'd5;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 32'h11;
    tick();
    n_vec++;
    if (rf_we !== 1'b0 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL b_push1: got we=%b busy1=%b, want 0 1", rf_we, busy1);
    end
    b_data = 32'h22;
    tick();
    b_valid = 1'b0;
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 3'd5 || rf_wd !== 32'h11 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL b_pop1: got we=%b wa=%0d wd=%h busy1=%b, want 1/5/11 1", rf_we, rf_wa, rf_wd, busy1);
    end
    tick();
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 3'd5 || rf_wd !== 32'h22 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL b_pop2: got we=%b wa=%0d wd=%h busy1=%b, want 1/5/22 0", rf_we, rf_wa, rf_wd, busy1);
    end
    tick();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL b_done: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    a_valid = 1'b1; a_addr = 3'd7; a_data = $urandom;
    for (int k = 1; k <= 4; k++) begin
      b_valid = 1'b1; b_addr = 3'(k); b_data = 32'h100 + k;
      #1;
      n_vec++;
      if (b_ready !== 1'b1) begin
        n_err++; $display("FAIL bp_ready k%0d: got %b, want 1", k, b_ready);
      end
      tick();
    end
    b_addr = 3'd6; b_data = 32'h999;
    #1;
    n_vec++;
    if (b_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full: got ready=%b, want 0", b_ready);
    end
    tick();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_vec++;
      if (rf_we !== 1'b1 || rf_wa !== 3'(k) || rf_wd !== 32'h100 + k) begin
        n_err++; $display("FAIL bp_drain k%0d: got we=%b wa=%0d wd=%h, want 1/%0d/%h", k, rf_we, rf_wa, rf_wd, k, 32'h100 + k);
      end
    end
    n_vec++;
    if (b_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_again: got %b, want 1", b_ready);
    end
    tick();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL bp_no_extra: got we=%b, want 0", rf_we);
    end
  endtask

  task automatic test_squash();
    idle_inputs();
    ra1 = 3'd2;
    a_valid = 1'b1; a_addr = 3'd7; a_data = 32'h7;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 32'hAA;
    tick();
    n_vec++;
    if (busy1 !== 1'b1) begin
      n_err++; $display("FAIL sq_pending: got busy1=%b, want 1", busy1);
    end
    a_addr = 3'd2; a_data = 32'hBB;
    b_addr = 3'd2; b_data = 32'hCC;
    tick();
    idle_inputs();
    #1;
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 3'd2 || rf_wd !== 32'hBB || busy1 !== 1'b0 || op1 !== 32'hBB) begin
      n_err++; $display("FAIL sq_write: got we=%b wa=%0d wd=%h busy1=%b op1=%h, want 1/2/bb 0 bb", rf_we, rf_wa, rf_wd, busy1, op1);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (rf_we !== 1'b0 || rf_wa !== 3'd2 || rf_wd !== 32'hBB) begin
        n_err++; $display("FAIL sq_pop%0d: got we=%b wa=%0d wd=%h, want 0/2/bb", k, rf_we, rf_wa, rf_wd);
      end
    end
    n_vec++;
    if (b_ready !== 1'b1) begin
      n_err++; $display("FAIL sq_empty: got ready=%b, want 1", b_ready);
    end
  endtask

  // Randomized traffic: every cycle all outputs are checked against the model.
  task automatic test_traffic(input string name, input int beats, input int a_pct,
                              input int b_pct, input int max_cyc);
    int  accepted;
    bit  done;
    accepted = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      if (accepted < beats) begin
        a_valid = ($urandom_range(99) < a_pct);
        b_valid = ($urandom_range(99) < b_pct);
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      a_addr = 3'($urandom_range(7)); a_data = $urandom;
      b_addr = 3'($urandom_range(7)); b_data = $urandom;
      ra1 = 3'($urandom_range(7)); ra2 = 3'($urandom_range(7));
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      #1;
      n_vec++;
      if ({rf_we, rf_wa, rf_wd} !== {m_we, m_wa, m_wd}) begin
        n_err++; $display("FAIL %s_rf cyc%0d: got we=%b wa=%0d wd=%h, want %b/%0d/%h", name, cyc, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd);
      end
      n_vec++;
      if (b_ready !== (mq.size() < DEPTH)) begin
        n_err++; $display("FAIL %s_ready cyc%0d: got %b, want %b", name, cyc, b_ready, mq.size() < DEPTH);
      end
      n_vec++;
      if (busy1 !== exp_busy(ra1) || busy2 !== exp_busy(ra2)) begin
        n_err++; $display("FAIL %s_busy cyc%0d: got %b%b, want %b%b", name, cyc, busy1, busy2, exp_busy(ra1), exp_busy(ra2));
      end
      n_vec++;
      if (op1 !== exp_op(ra1, rf_rd1) || op2 !== exp_op(ra2, rf_rd2)) begin
        n_err++; $display("FAIL %s_op cyc%0d: got %h %h, want %h %h", name, cyc, op1, op2, exp_op(ra1, rf_rd1), exp_op(ra2, rf_rd2));
      end
      if (accepted >= beats && mq.size() == 0 && !m_we) done = 1'b1;
      if (b_valid && mq.size() < DEPTH) accepted++;
      tick();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: accepted %0d of %0d beats, %0d left queued", name, accepted, beats, mq.size());
    end
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
    n_rst = 1'b0;
    model_clear();
    test_reset();
    test_a_only();
    test_b_order();
    test_backpressure();
    test_squash();
    test_traffic("wrap", 2 * DEPTH + 1, 50, 100, 400);
    test_traffic("random", 200, 35, 60, 4000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
